reset_counter_nbit: RTL and testbench

RESET_COUNTER_NBIT -- requirements
Module: reset_counter_nbit

---
 rtl/proc_reg_pkg.sv | 36 +++
 rtl/counter_next_calc.sv | 112 +++++++++++
 rtl/reset_counter_nbit.sv | 99 +++++++++
 tb/tb_reset_counter_nbit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_reg_pkg.sv
// Shared definitions for the bounded up/down/offset counter.
//   mode_e : bound behaviour, MODE_WRAP (0) or MODE_SAT (1)
//   op_e   : count operation chosen for one cycle, listed in priority order
//   sel_op : resolves the raw control inputs into a single op_e
package proc_reg_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_INC   = 3'd1,
    OP_DEC   = 3'd2,
    OP_ADD   = 3'd3,
    OP_WRITE = 3'd4,
    OP_RESET = 3'd5
  } op_e;

  // Priority: reset > write_en > add_en > inc/dec > hold.
  // inc and dec together cancel out and fall through to hold.
  function automatic op_e sel_op(input logic reset, input logic write_en,
                                 input logic add_en, input logic inc,
                                 input logic dec);
    op_e op;
    if (reset)               op = OP_RESET;
    else if (write_en)       op = OP_WRITE;
    else if (add_en)         op = OP_ADD;
    else if (inc && !dec)    op = OP_INC;
    else if (dec && !inc)    op = OP_DEC;
    else                     op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count calculation for reset_counter_nbit.
//   count, limit  : current registered count and upper bound
//   datain        : load value used by OP_WRITE
//   offset        : two's-complement offset used by OP_ADD
//   op            : operation selected for this cycle
//   next_count    : count value for the next edge (OP_RESET/OP_HOLD keep count;
//                   the top overrides on reset)
//   tc_evt        : a wrap or clamp happened this cycle
//   sat_evt       : a clamp happened this cycle (sets the sticky flag)
module counter_next_calc
  import proc_reg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] datain,
  input  logic [WIDTH-1:0] offset,
  input  op_e              op,
  output logic [WIDTH-1:0] next_count,
  output logic             tc_evt,
  output logic             sat_evt
);

  localparam mode_e MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
  // Two guard bits: count may sit above limit after a write, so the sum can
  // reach 2^WIDTH - 1 + 2^(WIDTH-1) - 1 and must not alias a negative value.
  localparam int RW = WIDTH + 2;
  localparam logic [RW-1:0] ONE = RW'(1);

  logic [RW-1:0] modulus;
  logic [RW-1:0] limit_x;
  logic [RW-1:0] sum;
  logic [RW-1:0] neg_sum;
  logic [RW-1:0] pos_rem;
  logic [RW-1:0] neg_rem;
  logic [RW-1:0] neg_wrap;
  logic          sum_neg;
  logic          sum_over;

  always_comb begin
    limit_x  = {2'b00, limit};
    modulus  = limit_x + ONE;
    sum      = {2'b00, count} + {{2{offset[WIDTH-1]}}, offset};
    sum_neg  = sum[RW-1];
    sum_over = !sum_neg && (sum > limit_x);
    neg_sum  = -sum;
    pos_rem  = sum % modulus;
    // Non-negative remainder of a negative sum r: m-1 - ((-r-1) mod m).
    neg_rem  = (neg_sum - ONE) % modulus;
    neg_wrap = modulus - ONE - neg_rem;
  end

  always_comb begin
    next_count = count;
    tc_evt     = 1'b0;
    sat_evt    = 1'b0;
    unique case (op)
      OP_WRITE: next_count = datain;
      OP_ADD: begin
        if (sum_neg) begin
          tc_evt = 1'b1;
          if (MODE == MODE_SAT) begin
            next_count = '0;
            sat_evt    = 1'b1;
          end else begin
            next_count = neg_wrap[WIDTH-1:0];
          end
        end else if (sum_over) begin
          tc_evt = 1'b1;
          if (MODE == MODE_SAT) begin
            next_count = limit;
            sat_evt    = 1'b1;
          end else begin
            next_count = pos_rem[WIDTH-1:0];
          end
        end else begin
          next_count = sum[WIDTH-1:0];
        end
      end
      OP_INC: begin
        if (count < limit) begin
          next_count = count + WIDTH'(1);
        end else begin
          tc_evt = 1'b1;
          if (MODE == MODE_SAT) begin
            next_count = limit;
            sat_evt    = 1'b1;
          end else begin
            next_count = '0;
          end
        end
      end
      OP_DEC: begin
        if (count != '0) begin
          next_count = count - WIDTH'(1);
        end else begin
          tc_evt = 1'b1;
          if (MODE == MODE_SAT) begin
            next_count = '0;
            sat_evt    = 1'b1;
          end else begin
            next_count = limit;
          end
        end
      end
      default: next_count = count;
    endcase
  end

endmodule

// File: rtl/reset_counter_nbit.sv
// Bounded counter with programmable upper limit, wrap or saturate behaviour.
//   clk, reset : clock and synchronous active-high reset
//   write_en   : load count from datain (unclamped), clears sat
//   inc, dec   : step by one; both together hold
//   add_en     : add signed offset
//   limit_we   : load limit from datain; count ops this cycle see the old limit
//   dataout    : registered count
//   limit      : registered upper bound
//   zero       : registered, dataout == 0
//   at_limit   : registered, dataout == limit
//   tc         : one-cycle pulse on any wrap or clamp
//   sat        : sticky clamp flag, cleared by reset or write_en
module reset_counter_nbit
  import proc_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SATURATE  = 0,
  parameter logic [WIDTH-1:0] LIMIT_RST = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [WIDTH-1:0] datain,
  input  logic             inc,
  input  logic             dec,
  input  logic             add_en,
  input  logic [WIDTH-1:0] offset,
  input  logic             limit_we,
  output logic [WIDTH-1:0] dataout,
  output logic [WIDTH-1:0] limit,
  output logic             zero,
  output logic             at_limit,
  output logic             tc,
  output logic             sat
);

  // Power-up values match the reset values.
  logic [WIDTH-1:0] count_q    = RESET_VAL;
  logic [WIDTH-1:0] limit_q    = LIMIT_RST;
  logic             zero_q     = (RESET_VAL == '0);
  logic             at_limit_q = (RESET_VAL == LIMIT_RST);
  logic             tc_q       = 1'b0;
  logic             sat_q      = 1'b0;

  op_e              op;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] next_limit;
  logic             tc_evt;
  logic             sat_evt;

  always_comb begin
    op         = sel_op(reset, write_en, add_en, inc, dec);
    next_limit = limit_we ? datain : limit_q;
  end

  counter_next_calc #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_calc (
    .count      (count_q),
    .limit      (limit_q),
    .datain     (datain),
    .offset     (offset),
    .op         (op),
    .next_count (next_count),
    .tc_evt     (tc_evt),
    .sat_evt    (sat_evt)
  );

  // zero/at_limit are registered from the next values so they line up with
  // dataout/limit on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= RESET_VAL;
      limit_q    <= LIMIT_RST;
      zero_q     <= (RESET_VAL == '0);
      at_limit_q <= (RESET_VAL == LIMIT_RST);
      tc_q       <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      count_q    <= next_count;
      limit_q    <= next_limit;
      zero_q     <= (next_count == '0);
      at_limit_q <= (next_count == next_limit);
      tc_q       <= tc_evt;
      if (write_en)     sat_q <= 1'b0;
      else if (sat_evt) sat_q <= 1'b1;
    end
  end

  assign dataout  = count_q;
  assign limit    = limit_q;
  assign zero     = zero_q;
  assign at_limit = at_limit_q;
  assign tc       = tc_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_reset_counter_nbit.sv
// Bench for reset_counter_nbit: two 8-bit instances (wrap and saturate) share
// one stimulus stream and are tracked by an arithmetic reference model; a
// 16-bit wrap instance covers the wide limit-update case.
module tb_reset_counter_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared 8-bit stimulus
  logic       reset = 1'b1, write_en = 1'b0, inc = 1'b0, dec = 1'b0;
  logic       add_en = 1'b0, limit_we = 1'b0;
  logic [7:0] datain = '0, offset = '0;

  logic [7:0] w_dataout, w_limit, s_dataout, s_limit;
  logic       w_zero, w_at_limit, w_tc, w_sat;
  logic       s_zero, s_at_limit, s_tc, s_sat;

  // 16-bit stimulus
  logic        r16_reset = 1'b1, r16_write_en = 1'b0, r16_inc = 1'b0, r16_dec = 1'b0;
  logic        r16_add_en = 1'b0, r16_limit_we = 1'b0;
  logic [15:0] r16_datain = '0, r16_offset = '0;
  logic [15:0] r16_dataout, r16_limit;
  logic        r16_zero, r16_at_limit, r16_tc, r16_sat;

  reset_counter_nbit #(.WIDTH(8), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .write_en(write_en), .datain(datain),
    .inc(inc), .dec(dec), .add_en(add_en), .offset(offset),
    .limit_we(limit_we), .dataout(w_dataout), .limit(w_limit),
    .zero(w_zero), .at_limit(w_at_limit), .tc(w_tc), .sat(w_sat));

  reset_counter_nbit #(.WIDTH(8), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .write_en(write_en), .datain(datain),
    .inc(inc), .dec(dec), .add_en(add_en), .offset(offset),
    .limit_we(limit_we), .dataout(s_dataout), .limit(s_limit),
    .zero(s_zero), .at_limit(s_at_limit), .tc(s_tc), .sat(s_sat));

  reset_counter_nbit #(.WIDTH(16), .SATURATE(0)) dut_16 (
    .clk(clk), .reset(r16_reset), .write_en(r16_write_en), .datain(r16_datain),
    .inc(r16_inc), .dec(r16_dec), .add_en(r16_add_en), .offset(r16_offset),
    .limit_we(r16_limit_we), .dataout(r16_dataout), .limit(r16_limit),
    .zero(r16_zero), .at_limit(r16_at_limit), .tc(r16_tc), .sat(r16_sat));

  int checks = 0;
  int errors = 0;

  // reference model state for the two 8-bit instances
  longint mw_cnt = 0, mw_lim = 255, ms_cnt = 0, ms_lim = 255;
  bit     mw_sat = 0, mw_tc = 0, ms_sat = 0, ms_tc = 0;

  // One cycle of the counter rules, in plain integer arithmetic.
  function automatic void model_step(input bit satm, input int w,
      input bit r, input bit we, input bit lwe, input bit ae, input bit i, input bit d,
      input longint din, input longint off,
      inout longint cnt, inout longint lim, inout bit sat, output bit tc);
    longint top, offs, res;
    top = (longint'(1) << w) - 1;
    tc  = 0;
    if (r) begin
      cnt = 0; lim = top; sat = 0;
      return;
    end
    if (we) begin
      cnt = din; sat = 0;
    end else if (ae) begin
      offs = (off > top / 2) ? off - (top + 1) : off;
      res  = cnt + offs;
      if (res >= 0 && res <= lim) cnt = res;
      else begin
        tc = 1;
        if (satm) begin
          sat = 1;
          cnt = (res < 0) ? 0 : lim;
        end else begin
          cnt = ((res % (lim + 1)) + lim + 1) % (lim + 1);
        end
      end
    end else if (i && !d) begin
      if (cnt < lim) cnt = cnt + 1;
      else begin
        tc = 1;
        if (satm) begin cnt = lim; sat = 1; end
        else cnt = 0;
      end
    end else if (d && !i) begin
      if (cnt > 0) cnt = cnt - 1;
      else begin
        tc = 1;
        if (satm) begin cnt = 0; sat = 1; end
        else cnt = lim;
      end
    end
    if (lwe) lim = din;
  endfunction

  task automatic step8(input bit r, input bit we, input bit lwe, input bit ae,
                       input bit i, input bit d, input logic [7:0] din,
                       input logic [7:0] off);
    reset = r; write_en = we; limit_we = lwe; add_en = ae;
    inc = i; dec = d; datain = din; offset = off;
    @(posedge clk); #1;
    model_step(0, 8, r, we, lwe, ae, i, d, longint'(din), longint'(off),
               mw_cnt, mw_lim, mw_sat, mw_tc);
    model_step(1, 8, r, we, lwe, ae, i, d, longint'(din), longint'(off),
               ms_cnt, ms_lim, ms_sat, ms_tc);
  endtask

  task automatic idle8();
    step8(0, 0, 0, 0, 0, 0, 8'd0, 8'd0);
  endtask

  task automatic step16(input bit r, input bit we, input bit lwe, input bit i,
                        input logic [15:0] din);
    r16_reset = r; r16_write_en = we; r16_limit_we = lwe; r16_inc = i;
    r16_dec = 1'b0; r16_add_en = 1'b0; r16_offset = '0; r16_datain = din;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({w_dataout, w_limit, w_tc, w_sat} !== {8'd0, 8'd255, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL powerup got %h want %h", {w_dataout, w_limit, w_tc, w_sat},
               {8'd0, 8'd255, 1'b0, 1'b0});
    end
    step8(1, 0, 0, 0, 0, 0, 8'd0, 8'd0);
    step16(1, 0, 0, 0, 16'd0);
    checks++;
    if ({w_dataout, w_limit, w_tc, w_sat, w_zero, w_at_limit} !== {8'd0, 8'd255, 4'b0010}) begin
      errors++;
      $display("FAIL reset_wrap got %h want %h",
               {w_dataout, w_limit, w_tc, w_sat, w_zero, w_at_limit}, {8'd0, 8'd255, 4'b0010});
    end
    checks++;
    if ({s_dataout, s_limit, s_tc, s_sat, s_zero, s_at_limit} !== {8'd0, 8'd255, 4'b0010}) begin
      errors++;
      $display("FAIL reset_sat got %h want %h",
               {s_dataout, s_limit, s_tc, s_sat, s_zero, s_at_limit}, {8'd0, 8'd255, 4'b0010});
    end
    checks++;
    if ({r16_dataout, r16_limit, r16_tc, r16_sat, r16_zero, r16_at_limit} !==
        {16'd0, 16'hFFFF, 4'b0010}) begin
      errors++;
      $display("FAIL reset_16 got %h want %h",
               {r16_dataout, r16_limit, r16_tc, r16_sat, r16_zero, r16_at_limit},
               {16'd0, 16'hFFFF, 4'b0010});
    end
  endtask

  task automatic test_wrap_inc();
    step8(0, 1, 1, 0, 0, 0, 8'd9, 8'd0);   // count = limit = 9
    step8(0, 0, 0, 0, 1, 0, 8'd0, 8'd0);   // inc at limit
    checks++;
    if ({w_dataout, w_tc, w_zero} !== {8'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_inc got %h want %h", {w_dataout, w_tc, w_zero}, {8'd0, 1'b1, 1'b1});
    end
    idle8();
    checks++;
    if (w_tc !== 1'b0) begin
      errors++;
      $display("FAIL wrap_inc_tc_pulse got %b want 0", w_tc);
    end
  endtask

  task automatic test_sat_add();
    step8(0, 1, 1, 0, 0, 0, 8'd200, 8'd0);
    step8(0, 1, 0, 0, 0, 0, 8'd195, 8'd0);
    step8(0, 0, 0, 1, 0, 0, 8'd0, 8'd10);
    checks++;
    if ({s_dataout, s_tc, s_sat, s_at_limit} !== {8'd200, 3'b111}) begin
      errors++;
      $display("FAIL sat_add got %h want %h", {s_dataout, s_tc, s_sat, s_at_limit}, {8'd200, 3'b111});
    end
    step8(0, 1, 0, 0, 0, 0, 8'd5, 8'd0);
    checks++;
    if ({s_dataout, s_tc, s_sat} !== {8'd5, 2'b00}) begin
      errors++;
      $display("FAIL sat_clear got %h want %h", {s_dataout, s_tc, s_sat}, {8'd5, 2'b00});
    end
  endtask

  task automatic test_wrap_add_neg();
    step8(1, 0, 0, 0, 0, 0, 8'd0, 8'd0);
    step8(0, 1, 0, 0, 0, 0, 8'd3, 8'd0);
    step8(0, 0, 0, 1, 0, 0, 8'd0, 8'hFB);
    checks++;
    if ({w_dataout, w_tc} !== {8'd254, 1'b1}) begin
      errors++;
      $display("FAIL wrap_add_neg got %h want %h", {w_dataout, w_tc}, {8'd254, 1'b1});
    end
  endtask

  task automatic test_inc_dec_both();
    step8(0, 1, 0, 0, 0, 0, 8'd7, 8'd0);
    step8(0, 0, 0, 0, 1, 1, 8'd0, 8'd0);
    checks++;
    if ({w_dataout, w_tc, s_dataout, s_tc} !== {8'd7, 1'b0, 8'd7, 1'b0}) begin
      errors++;
      $display("FAIL inc_dec_hold got %h want %h", {w_dataout, w_tc, s_dataout, s_tc},
               {8'd7, 1'b0, 8'd7, 1'b0});
    end
    step8(0, 1, 0, 0, 1, 0, 8'd42, 8'd0);
    checks++;
    if (w_dataout !== 8'd42) begin
      errors++;
      $display("FAIL write_over_inc got %0d want 42", w_dataout);
    end
  endtask

  task automatic test_reset_override();
    step8(0, 1, 0, 0, 0, 0, 8'd0, 8'd0);
    step8(0, 0, 0, 0, 0, 1, 8'd0, 8'd0);   // sat instance clamps at 0
    step8(0, 0, 0, 1, 0, 0, 8'd0, 8'd100);
    checks++;
    if ({s_dataout, s_sat} !== {8'd100, 1'b1}) begin
      errors++;
      $display("FAIL sticky_sat got %h want %h", {s_dataout, s_sat}, {8'd100, 1'b1});
    end
    step8(1, 1, 1, 0, 0, 0, 8'd77, 8'd0);
    checks++;
    if ({s_dataout, s_limit, s_sat, w_dataout, w_limit} !== {8'd0, 8'd255, 1'b0, 8'd0, 8'd255}) begin
      errors++;
      $display("FAIL reset_override got %h want %h", {s_dataout, s_limit, s_sat, w_dataout, w_limit},
               {8'd0, 8'd255, 1'b0, 8'd0, 8'd255});
    end
  endtask

  task automatic test_limit_same_edge();
    step16(0, 1, 0, 0, 16'h0010);
    step16(0, 0, 1, 1, 16'h0010);
    checks++;
    if ({r16_dataout, r16_limit, r16_at_limit} !== {16'h0011, 16'h0010, 1'b0}) begin
      errors++;
      $display("FAIL limit_same_edge got %h want %h", {r16_dataout, r16_limit, r16_at_limit},
               {16'h0011, 16'h0010, 1'b0});
    end
    step16(0, 0, 0, 1, 16'h0000);          // count above new limit wraps
    checks++;
    if ({r16_dataout, r16_tc, r16_zero} !== {16'h0000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL limit_16_wrap got %h want %h", {r16_dataout, r16_tc, r16_zero},
               {16'h0000, 1'b1, 1'b1});
    end
  endtask

  task automatic test_random();
    logic [19:0] exp_w, exp_s, got_w, got_s;
    logic [7:0]  din;
    for (int n = 0; n < 600; n++) begin
      din = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
      step8($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 25,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            din, 8'($urandom_range(0, 255)));
      exp_w = {mw_cnt[7:0], mw_lim[7:0], mw_tc, mw_sat, mw_cnt == 0, mw_cnt == mw_lim};
      exp_s = {ms_cnt[7:0], ms_lim[7:0], ms_tc, ms_sat, ms_cnt == 0, ms_cnt == ms_lim};
      got_w = {w_dataout, w_limit, w_tc, w_sat, w_zero, w_at_limit};
      got_s = {s_dataout, s_limit, s_tc, s_sat, s_zero, s_at_limit};
      checks++;
      if (got_w !== exp_w) begin
        errors++;
        $display("FAIL random_wrap cycle %0d got %h want %h", n, got_w, exp_w);
      end
      checks++;
      if (got_s !== exp_s) begin
        errors++;
        $display("FAIL random_sat cycle %0d got %h want %h", n, got_s, exp_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_inc();
    test_sat_add();
    test_wrap_add_neg();
    test_inc_dec_both();
    test_reset_override();
    test_limit_same_edge();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
